// File: rtl/gpio_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pkg
// Shared definitions for the GPIO block's input-conditioning logic.
//   - 2-bit button FSM state encoding (ST_* constants and btn_state_e enum)
//   - default debounce window for a 100 MHz system clock (10 ms)
//   - is_level_state(): states in which the debounced level reads as pressed
// -----------------------------------------------------------------------------
package gpio_pkg;

   localparam logic [1:0] ST_RELEASED    = 2'd0;
   localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
   localparam logic [1:0] ST_HELD        = 2'd2;
   localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

   typedef enum logic [1:0] {
      BTN_RELEASED    = ST_RELEASED,
      BTN_PRESS_CHK   = ST_PRESS_CHK,
      BTN_HELD        = ST_HELD,
      BTN_RELEASE_CHK = ST_RELEASE_CHK
   } btn_state_e;

   // 10 ms of stability at 100 MHz.
   localparam int unsigned DEBOUNCE_CYCLES_100MHZ = 1_000_000;

   // The button counts as pressed once a press is accepted and until a
   // release is accepted, including while a release is still being checked.
   function automatic logic is_level_state(input btn_state_e s);
      return (s == BTN_HELD) || (s == BTN_RELEASE_CHK);
   endfunction

endpackage : gpio_pkg

// File: rtl/btn_press_detector_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Parameterised-width two-flop synchroniser for asynchronous inputs
// (buttons, switches). Each bit is synchronised independently; there is no
// bus coherency across bits.
// Ports:
//   clk  in          destination clock
//   rst  in          synchronous active-high reset, clears both stages to 0
//   d    in  [W-1:0] asynchronous input
//   q    out [W-1:0] synchronised output (second stage)
// -----------------------------------------------------------------------------
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] s1_d, s1_q;
   logic [WIDTH-1:0] s2_d, s2_q;

   always_comb begin
      s1_d = d;
      s2_d = s1_q;
   end

   // NOTE: sequential state is written with non-blocking assignments so every
   // flop samples its pre-edge inputs; blocking here would collapse the chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign q = s2_q;

endmodule : sync_2ff

// File: rtl/btn_press_detector.sv
// -----------------------------------------------------------------------------
// btn_press_detector
// Conditions one raw push-button: two-flop synchronisation, debounce via a
// stability counter and a four-state FSM, then registered single-cycle
// press/release pulses and a clean debounced level.
//
// Optional feature macro: BTN_AUTO_REPEAT_EN
//   When defined, a hold counter runs while HELD; press_pulse fires again at
//   HOLD_CYCLES into the hold and every REPEAT_CYCLES after that. When not
//   defined, the hold logic is not built and HOLD/REPEAT_CYCLES are unused.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles required to accept a level change (>= 1)
//   HOLD_CYCLES      cycles in HELD before the first auto-repeat pulse
//   REPEAT_CYCLES    auto-repeat period after the first repeat
// Ports:
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   btn_in         in   raw asynchronous button, 1 = pressed
//   btn_level      out  debounced level (1 in HELD / RELEASE_CHK)
//   press_pulse    out  one-cycle pulse on accepted press (and auto-repeat)
//   release_pulse  out  one-cycle pulse on accepted release
// -----------------------------------------------------------------------------
module btn_press_detector
   import gpio_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100MHZ,
   parameter int unsigned HOLD_CYCLES     = 50_000_000,
   parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse
);

   // Zero-length windows have no meaning for any of the counters.
   if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
      $error("btn_press_detector: DEBOUNCE/HOLD/REPEAT_CYCLES must be >= 1");
   end

   localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   // ---------------------------------------------------------------------
   // Synchroniser: the FSM only ever looks at the second stage.
   // ---------------------------------------------------------------------
   logic btn_s;

   sync_2ff #(
      .WIDTH (1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_in),
      .q   (btn_s)
   );

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   btn_state_e       state_d, state_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             btn_level_d, btn_level_q;
   logic             press_d, press_q;
   logic             release_d, release_q;

`ifdef BTN_AUTO_REPEAT_EN
   localparam int unsigned HOLD_TOP = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES
                                                                     : REPEAT_CYCLES;
   localparam int unsigned         HOLD_W   = $clog2(HOLD_TOP + 1);
   localparam logic [HOLD_W-1:0]   HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [HOLD_W-1:0]   REP_MAX  = HOLD_W'(REPEAT_CYCLES - 1);

   logic [HOLD_W-1:0] hold_cnt_d, hold_cnt_q;
   // Set once the first (HOLD_CYCLES) repeat has fired; the hold counter then
   // measures REPEAT_CYCLES periods instead.
   logic              repeating_d, repeating_q;
`endif

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   // NOTE: every signal assigned here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      hold_cnt_d  = hold_cnt_q;
      repeating_d = repeating_q;
`endif

      unique case (state_q)
         BTN_RELEASED: begin
            if (btn_s) begin
               state_d = BTN_PRESS_CHK;
               cnt_d   = '0;
            end
         end

         BTN_PRESS_CHK: begin
            if (!btn_s) begin
               // Glitch: drop back and discard the partial window.
               state_d = BTN_RELEASED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = BTN_HELD;
               cnt_d   = '0;
               press_d = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
               hold_cnt_d  = '0;
               repeating_d = 1'b0;
`endif
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         BTN_HELD: begin
            if (!btn_s) begin
               state_d = BTN_RELEASE_CHK;
               cnt_d   = '0;
`ifdef BTN_AUTO_REPEAT_EN
               hold_cnt_d  = '0;
               repeating_d = 1'b0;
`endif
            end
`ifdef BTN_AUTO_REPEAT_EN
            else if (hold_cnt_q == (repeating_q ? REP_MAX : HOLD_MAX)) begin
               press_d     = 1'b1;
               hold_cnt_d  = '0;
               repeating_d = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
`endif
         end

         BTN_RELEASE_CHK: begin
            if (btn_s) begin
               // Release bounce: back to HELD silently, hold timing restarts.
               state_d = BTN_HELD;
               cnt_d   = '0;
`ifdef BTN_AUTO_REPEAT_EN
               hold_cnt_d  = '0;
               repeating_d = 1'b0;
`endif
            end else if (cnt_q == CNT_MAX) begin
               state_d   = BTN_RELEASED;
               cnt_d     = '0;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = BTN_RELEASED;
            cnt_d   = '0;
         end
      endcase

      // Registered level follows the state being entered, so it changes in
      // the same cycle as the matching pulse.
      btn_level_d = is_level_state(state_d);
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= BTN_RELEASED;
         cnt_q       <= '0;
         btn_level_q <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
         hold_cnt_q  <= '0;
         repeating_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         btn_level_q <= btn_level_d;
         press_q     <= press_d;
         release_q   <= release_d;
`ifdef BTN_AUTO_REPEAT_EN
         hold_cnt_q  <= hold_cnt_d;
         repeating_q <= repeating_d;
`endif
      end
   end

   assign btn_level     = btn_level_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;

endmodule : btn_press_detector

// File: tb/tb_btn_press_detector.sv
// -----------------------------------------------------------------------------
// tb_btn_press_detector
// Directed bench for btn_press_detector with DEBOUNCE=4, HOLD=16, REPEAT=8.
// Each stimulus step pushes the pulse it should cause (kind + cycle) into a
// queue; a negedge monitor pops and compares whenever a pulse appears and
// flags pulses that are late, missing or unexpected.
// Define BTN_AUTO_REPEAT_EN for both bench and RTL to check auto-repeat.
// -----------------------------------------------------------------------------
module tb_btn_press_detector;

   localparam int unsigned DB   = 4;
   localparam int unsigned HOLD = 16;
   localparam int unsigned REP  = 8;
   // Sampled-at-edge-k to pulse-visible-after-edge latency.
   localparam int unsigned LAT  = 2 + DB;

   logic clk    = 1'b0;
   logic rst    = 1'b1;
   logic btn_in = 1'b0;
   logic btn_level, press_pulse, release_pulse;

   btn_press_detector #(
      .DEBOUNCE_CYCLES (DB),
      .HOLD_CYCLES     (HOLD),
      .REPEAT_CYCLES   (REP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_in        (btn_in),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse)
   );

   always #5 clk = ~clk;

   // cyc == n at the negedge following rising edge n.
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum int {EV_PRESS = 1, EV_RELEASE = 2} ev_e;
   typedef struct {
      ev_e         kind;
      int unsigned cycle;
   } ev_t;

   ev_t exp_q[$];
   ev_t ev;
   int  n_assert     = 0;
   int  n_fail       = 0;
   int  n_press_exp  = 0;
   int  n_rel_exp    = 0;
   int  n_press_seen = 0;
   int  n_rel_seen   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   task automatic push(input ev_e kind, input int unsigned at);
      ev_t e;
      e.kind  = kind;
      e.cycle = at;
      exp_q.push_back(e);
      if (kind == EV_PRESS) n_press_exp++;
      else                  n_rel_exp++;
   endtask

   // Drive on a negedge; k is the rising edge that first samples the value.
   task automatic set_btn(input logic v, output int unsigned k);
      @(negedge clk);
      btn_in = v;
      k = cyc + 1;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------------------------------------------------------------
   // Monitor / scoreboard
   // ---------------------------------------------------------------------
   always @(negedge clk) begin
      if (!rst) begin
         if (press_pulse || release_pulse) begin
            if (press_pulse)   n_press_seen++;
            if (release_pulse) n_rel_seen++;
            check("pulse_exclusive", 32'(press_pulse & release_pulse), 32'd0);
            if (exp_q.size() == 0) begin
               check("unexpected_pulse", 32'(press_pulse ? EV_PRESS : EV_RELEASE), 32'd0);
            end else begin
               ev = exp_q.pop_front();
               check("pulse_kind", 32'(press_pulse ? EV_PRESS : EV_RELEASE), 32'(ev.kind));
               check("pulse_cycle", cyc, ev.cycle);
               check("level_with_pulse", 32'(btn_level), 32'(press_pulse));
            end
         end else if (exp_q.size() != 0 && cyc > exp_q[0].cycle) begin
            ev = exp_q.pop_front();
            check("missed_pulse_cycle", cyc, ev.cycle);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      int unsigned k, k2;

      // Reset state
      wait_cyc(3);
      check("rst_level",   32'(btn_level),     32'd0);
      check("rst_press",   32'(press_pulse),   32'd0);
      check("rst_release", 32'(release_pulse), 32'd0);
      rst = 1'b0;

      // Clean press
      set_btn(1'b1, k);
      push(EV_PRESS, k + LAT);
      wait_cyc(12);
      check("press_level", 32'(btn_level), 32'd1);

      // Clean release
      set_btn(1'b0, k);
      push(EV_RELEASE, k + LAT);
      wait_cyc(12);
      check("release_level", 32'(btn_level), 32'd0);

      // Press bounce: 1 for 3 samples, 0 for 1, then steady 1
      set_btn(1'b1, k);
      wait_cyc(2);
      set_btn(1'b0, k);
      set_btn(1'b1, k2);
      push(EV_PRESS, k2 + LAT);
      wait_cyc(12);
      check("bounce_press_level", 32'(btn_level), 32'd1);

      // Single-sample release glitch while HELD: nothing happens
      set_btn(1'b0, k);
      set_btn(1'b1, k);
      wait_cyc(12);
      check("glitch_hold_level", 32'(btn_level), 32'd1);

      set_btn(1'b0, k);
      push(EV_RELEASE, k + LAT);
      wait_cyc(12);

      // Reset in PRESS_CHK with cnt == 2
      set_btn(1'b1, k);
      wait_cyc(5);
      rst = 1'b1;
      wait_cyc(1);
      check("rst_chk_level",   32'(btn_level),     32'd0);
      check("rst_chk_press",   32'(press_pulse),   32'd0);
      check("rst_chk_release", 32'(release_pulse), 32'd0);
      rst = 1'b0;
      push(EV_PRESS, cyc + 1 + LAT);
      wait_cyc(12);

      // Reset while HELD: no release, re-detected as a new press
      check("pre_rst_held_level", 32'(btn_level), 32'd1);
      rst = 1'b1;
      wait_cyc(1);
      check("rst_held_level",   32'(btn_level),     32'd0);
      check("rst_held_release", 32'(release_pulse), 32'd0);
      rst = 1'b0;
      push(EV_PRESS, cyc + 1 + LAT);
      wait_cyc(12);
      check("post_rst_level", 32'(btn_level), 32'd1);
      set_btn(1'b0, k);
      push(EV_RELEASE, k + LAT);
      wait_cyc(12);

      // Random press/release pairs, held short of the first auto-repeat
      for (int i = 0; i < 20; i++) begin
         set_btn(1'b1, k);
         push(EV_PRESS, k + LAT);
         wait_cyc($urandom_range(10, 14));
         set_btn(1'b0, k);
         push(EV_RELEASE, k + LAT);
         wait_cyc($urandom_range(10, 14));
      end

      // Long hold: auto-repeat pulses only when the feature is built
      set_btn(1'b1, k);
      push(EV_PRESS, k + LAT);
`ifdef BTN_AUTO_REPEAT_EN
      for (int t = HOLD; t <= 56; t += REP) push(EV_PRESS, k + LAT + t);
`endif
      wait_cyc(66);
      check("long_hold_level", 32'(btn_level), 32'd1);
      set_btn(1'b0, k);
      push(EV_RELEASE, k + LAT);
      wait_cyc(12);

      // Totals
      check("queue_drained",  32'(exp_q.size()), 32'd0);
      check("press_count",    32'(n_press_seen), 32'(n_press_exp));
      check("release_count",  32'(n_rel_seen),   32'(n_rel_exp));
      check("final_level",    32'(btn_level),    32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_btn_press_detector

// File: doc/btn_press_detector.md
Name: btn_press_detector

Overview:
- Per-button conditioning stage feeding the GPIO block's button-press counters.
- Takes one raw asynchronous push-button input and synchronises it into the clock domain.
- Debounces it with a stability counter and FSM.
- Emits single-cycle press/release pulses plus a clean level; the GPIO block instantiates four, one per button, and adds press_pulse to its counter.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal range >= 1
HOLD_CYCLES, 50000000, cycles held before first auto-repeat pulse (used only with BTN_AUTO_REPEAT_EN)
REPEAT_CYCLES, 10000000, period of auto-repeat pulses after HOLD_CYCLES (used only with BTN_AUTO_REPEAT_EN)

Ports:
clk  input  1  system clock, driven from s_axi_aclk
rst  input  1  synchronous active-high reset (parent drives ~s_axi_aresetn)
btn_in  input  1  raw asynchronous button, 1 = pressed
btn_level  output  1  debounced level, 1 while in HELD or RELEASE_CHK
press_pulse  output  1  one-cycle pulse on accepted press (and auto-repeat when enabled)
release_pulse  output  1  one-cycle pulse on accepted release

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high; all state updates on rising edge of clk.
- Synchroniser: 2 flops, s1 <= btn_in, s2 <= s1; reset value 0. FSM uses s2 only.
- Stability counter cnt: width $clog2(DEBOUNCE_CYCLES+1); cleared on every state entry; never wraps within a check window.
- FSM states and transitions:
  - RELEASED: if s2=1 -> PRESS_CHK, cnt <= 0.
  - PRESS_CHK:
    - if s2=0 -> RELEASED, no pulse (glitch rejected).
    - else if cnt == DEBOUNCE_CYCLES-1 -> HELD, press_pulse <= 1.
    - else cnt++.
  - HELD: if s2=0 -> RELEASE_CHK, cnt <= 0.
  - RELEASE_CHK:
    - if s2=1 -> HELD, no pulse.
    - else if cnt == DEBOUNCE_CYCLES-1 -> RELEASED, release_pulse <= 1.
    - else cnt++.
- Outputs are registered. Both pulses are high for exactly one cycle and are never high together.
- Latency: btn_in first sampled 1 at edge k (stable thereafter); FSM enters PRESS_CHK at edge k+2; press_pulse is high in the cycle after edge k+2+DEBOUNCE_CYCLES. Release latency is the same.
- btn_level rises in the same cycle as press_pulse. It falls in the same cycle as release_pulse.
- A bounce shorter than DEBOUNCE_CYCLES restarts the full window on the next transition; counting never accumulates across glitches.
- Reset values (all outputs and state): state RELEASED, cnt 0, s1/s2 0, btn_level 0, press_pulse 0, release_pulse 0.
- Reset mid-check: aborted, no pulse emitted.
- Reset while HELD: no release_pulse.
- Button held through reset deassertion: detected as a new press after normal latency.

Optional Feature:
BTN_AUTO_REPEAT_EN
- Defined:
  - HELD runs a hold counter from entry.
  - At HELD_count == HOLD_CYCLES-1, press_pulse fires once.
  - Thereafter press_pulse fires every REPEAT_CYCLES while still HELD.
  - Hold counter resets on leaving HELD.
  - A RELEASE_CHK that returns to HELD restarts the hold counter from 0.
- Undefined: exactly one press_pulse per accepted press; the hold counter and both parameters are unused and no logic is synthesised.

Decomposition:
- Shared package gpio_pkg holds:
  - 2-bit FSM state encoding localparams: ST_RELEASED=0, ST_PRESS_CHK=1, ST_HELD=2, ST_RELEASE_CHK=3.
  - Default debounce constant for 100 MHz.
- One natural sub-module: sync_2ff (parameterised-width two-flop synchroniser, reset to 0), reused later for the switch inputs.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, REPEAT_CYCLES=8):
- Clean press: btn_in 0->1 sampled at edge 10, held -> press_pulse high only in cycle after edge 16, btn_level=1 from edge 16; no release_pulse.
- Bounce: btn_in 1 for 3 cycles, 0 for 1, then 1 steady -> no pulse during glitch; single press_pulse 6 cycles after the final rising sample.
- Clean release after HELD: btn_in 1->0 sampled at edge 40 -> release_pulse high only after edge 46, btn_level=0 from edge 46.
- Reset mid-operation: rst=1 for one cycle while in PRESS_CHK (cnt=2) -> no pulse, all outputs 0. Same check while HELD -> no release_pulse. With btn_in still 1, press_pulse 7 cycles after rst falls.
- Pulse width/exclusivity: 20 random press/release cycles with spacing >= 10 cycles -> exactly 20 press_pulse and 20 release_pulse, each one cycle wide, never simultaneous.
- With BTN_AUTO_REPEAT_EN: hold 60 cycles after acceptance -> press_pulses at HELD cycle 0, 16, 24, 32, 40, 48, 56; without macro -> only the first.
